// File: rtl/neo_linebuf_wr_if.sv
// neo_linebuf_wr_if: sprite pixel write bus and display read bus
// of the double-banked line buffer.
interface neo_linebuf_wr_if;
    logic        LOAD;
    logic [8:0]  XPOS;
    logic [7:0]  PAL;
    logic        PIX_EN;
    logic [3:0]  GAD;
    logic [3:0]  GBD;
    logic        DOTA;
    logic        DOTB;
    logic        LINE_SWAP;
    logic        RD_EN;
    logic [8:0]  RD_X;
    logic [11:0] RD_DATA;
    logic        RD_VALID;
    logic        WR_BANK;
    logic [8:0]  PIX_CNT;

    modport master (
        output LOAD, XPOS, PAL, PIX_EN, GAD, GBD, DOTA, DOTB,
        output LINE_SWAP, RD_EN, RD_X,
        input  RD_DATA, RD_VALID, WR_BANK, PIX_CNT
    );

    modport slave (
        input  LOAD, XPOS, PAL, PIX_EN, GAD, GBD, DOTA, DOTB,
        input  LINE_SWAP, RD_EN, RD_X,
        output RD_DATA, RD_VALID, WR_BANK, PIX_CNT
    );
endinterface

// File: rtl/neo_linebuf_wr.sv
// neo_linebuf_wr: double-banked sprite line buffer; the sprite side
// writes pixel pairs into one bank while the display reads-and-clears the other.
module neo_linebuf_wr #(
    parameter int LB_WIDTH = 384
) (
    input  logic        CLK_12M,
    input  logic        nRESET,
    input  logic        LOAD,
    input  logic [8:0]  XPOS,
    input  logic [7:0]  PAL,
    input  logic        PIX_EN,
    input  logic [3:0]  GAD,
    input  logic [3:0]  GBD,
    input  logic        DOTA,
    input  logic        DOTB,
    input  logic        LINE_SWAP,
    input  logic        RD_EN,
    input  logic [8:0]  RD_X,
    output logic [11:0] RD_DATA,
    output logic        RD_VALID,
    output logic        WR_BANK,
    output logic [8:0]  PIX_CNT
);
    localparam logic [9:0] LBW = 10'(LB_WIDTH);
    localparam logic [9:0] CNT_MAX = 10'd511;

    logic [11:0] bank0_q [LB_WIDTH];
    logic [11:0] bank1_q [LB_WIDTH];

    logic [8:0]  x_q, x_d;
    logic [7:0]  pal_q, pal_d;
    logic        bank_q, bank_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [11:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    logic [8:0]  xa, xb;
    logic        wa, wb;
    logic [11:0] pix_a, pix_b;
    logic [9:0]  cnt_sum;
    logic        rd_in;
    logic        rd_clr;
    logic [8:0]  rd_idx;
    logic [11:0] rd_word;

    // A LOAD in the same cycle as a pixel pair takes effect for that pair.
    always_comb begin
        xa    = LOAD ? XPOS : x_q;
        pal_d = LOAD ? PAL  : pal_q;
        xb    = xa + 9'd1;
        x_d   = PIX_EN ? xa + 9'd2 : xa;
        pix_a = {pal_d, GAD};
        pix_b = {pal_d, GBD};
        wa    = PIX_EN && DOTA && ({1'b0, xa} < LBW);
        wb    = PIX_EN && DOTB && ({1'b0, xb} < LBW);
    end

    always_comb begin
        cnt_sum = {1'b0, cnt_q} + {9'd0, wa} + {9'd0, wb};
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        if (LINE_SWAP) begin
            bank_d = ~bank_q;
            cnt_d  = '0;
        end else if (cnt_sum > CNT_MAX) begin
            cnt_d = CNT_MAX[8:0];
        end else begin
            cnt_d = cnt_sum[8:0];
        end
    end

    // The read side always uses the bank the writer is not using.
    always_comb begin
        rd_in      = ({1'b0, RD_X} < LBW);
        rd_clr     = RD_EN && rd_in;
        rd_idx     = rd_in ? RD_X : '0;
        rd_word    = bank_q ? bank0_q[rd_idx] : bank1_q[rd_idx];
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (RD_EN) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rd_in ? rd_word : '0;
        end
    end

    always_ff @(posedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            x_q        <= '0;
            pal_q      <= '0;
            bank_q     <= 1'b0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            x_q        <= x_d;
            pal_q      <= pal_d;
            bank_q     <= bank_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Bank storage is not reset; it is emptied by reading it.
    always_ff @(posedge CLK_12M) begin
        if (!bank_q) begin
            if (wa) bank0_q[xa] <= pix_a;
            if (wb) bank0_q[xb] <= pix_b;
        end else if (rd_clr) begin
            bank0_q[rd_idx] <= '0;
        end
    end

    always_ff @(posedge CLK_12M) begin
        if (bank_q) begin
            if (wa) bank1_q[xa] <= pix_a;
            if (wb) bank1_q[xb] <= pix_b;
        end else if (rd_clr) begin
            bank1_q[rd_idx] <= '0;
        end
    end

    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
    assign WR_BANK  = bank_q;
    assign PIX_CNT  = cnt_q;
endmodule

// File: tb/tb_neo_linebuf_wr.sv
// tb_neo_linebuf_wr: directed scenarios plus randomized traffic checked
// against a per-pixel line-buffer model.
module tb_neo_linebuf_wr;
    localparam int LBW = 384;

    logic clk = 1'b0;
    logic nreset = 1'b0;

    initial forever #5 clk = ~clk;

    neo_linebuf_wr_if bus();

    neo_linebuf_wr #(.LB_WIDTH(LBW)) dut (
        .CLK_12M   (clk),
        .nRESET    (nreset),
        .LOAD      (bus.LOAD),
        .XPOS      (bus.XPOS),
        .PAL       (bus.PAL),
        .PIX_EN    (bus.PIX_EN),
        .GAD       (bus.GAD),
        .GBD       (bus.GBD),
        .DOTA      (bus.DOTA),
        .DOTB      (bus.DOTB),
        .LINE_SWAP (bus.LINE_SWAP),
        .RD_EN     (bus.RD_EN),
        .RD_X      (bus.RD_X),
        .RD_DATA   (bus.RD_DATA),
        .RD_VALID  (bus.RD_VALID),
        .WR_BANK   (bus.WR_BANK),
        .PIX_CNT   (bus.PIX_CNT)
    );

    int checks = 0;
    int errors = 0;

    logic [11:0] mb [2][512];
    int          m_bank, m_x, m_pal, m_cnt;
    logic [11:0] m_rd;
    logic        m_rv;

    task automatic reset_model();
        m_bank = 0; m_x = 0; m_pal = 0; m_cnt = 0;
        m_rd = '0; m_rv = 1'b0;
    endtask

    // One clock edge of the line buffer, from the behavioural rules.
    task automatic model_step();
        int x, p, acc, xb;
        logic [11:0] rv;
        rv = '0;
        if (bus.RD_EN && int'(bus.RD_X) < LBW) begin
            rv = mb[1 - m_bank][bus.RD_X];
            mb[1 - m_bank][bus.RD_X] = '0;
        end
        if (!nreset) return;
        m_rv = bus.RD_EN;
        if (bus.RD_EN) m_rd = rv;
        x = bus.LOAD ? int'(bus.XPOS) : m_x;
        p = bus.LOAD ? int'(bus.PAL) : m_pal;
        acc = 0;
        if (bus.PIX_EN) begin
            xb = (x + 1) % 512;
            if (bus.DOTA && x < LBW) begin
                mb[m_bank][x] = {p[7:0], bus.GAD};
                acc++;
            end
            if (bus.DOTB && xb < LBW) begin
                mb[m_bank][xb] = {p[7:0], bus.GBD};
                acc++;
            end
            x = (x + 2) % 512;
        end
        m_x = x;
        m_pal = p;
        if (bus.LINE_SWAP) begin
            m_bank = 1 - m_bank;
            m_cnt = 0;
        end else begin
            m_cnt = (m_cnt + acc > 511) ? 511 : m_cnt + acc;
        end
    endtask

    task automatic idle();
        bus.LOAD = 0; bus.XPOS = '0; bus.PAL = '0;
        bus.PIX_EN = 0; bus.GAD = '0; bus.GBD = '0;
        bus.DOTA = 0; bus.DOTB = 0; bus.LINE_SWAP = 0;
        bus.RD_EN = 0; bus.RD_X = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic pair(input logic [3:0] a, input logic [3:0] b,
                        input logic da, input logic db);
        bus.PIX_EN = 1; bus.GAD = a; bus.GBD = b;
        bus.DOTA = da; bus.DOTB = db;
    endtask

    task automatic read_at(input int addr);
        bus.RD_EN = 1; bus.RD_X = 9'(addr);
        tick();
        bus.RD_EN = 0;
    endtask

    task automatic test_reset();
        idle();
        reset_model();
        for (int i = 0; i < 512; i++) begin
            mb[0][i] = '0; mb[1][i] = '0;
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.WR_BANK !== 1'b0 || bus.PIX_CNT !== 9'd0) begin
            errors++;
            $display("FAIL reset_ctl: got bank=%0d cnt=%0d, want 0/0",
                     bus.WR_BANK, bus.PIX_CNT);
        end
        checks++;
        if (bus.RD_VALID !== 1'b0 || bus.RD_DATA !== 12'h000) begin
            errors++;
            $display("FAIL reset_rd: got v=%0d d=%h, want 0/000",
                     bus.RD_VALID, bus.RD_DATA);
        end
        @(negedge clk);
        nreset = 1;
        tick();
        checks++;
        if (bus.WR_BANK !== 1'b0 || bus.PIX_CNT !== 9'd0 || bus.RD_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got bank=%0d cnt=%0d v=%0d, want 0/0/0",
                     bus.WR_BANK, bus.PIX_CNT, bus.RD_VALID);
        end
    endtask

    // Uninitialised storage is emptied by one read pass per bank.
    task automatic clear_banks();
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < LBW; i++) read_at(i);
            bus.LINE_SWAP = 1;
            tick();
            bus.LINE_SWAP = 0;
        end
        read_at(0);
        checks++;
        if (bus.RD_DATA !== 12'h000 || bus.WR_BANK !== 1'b0) begin
            errors++;
            $display("FAIL clear_pass: got d=%h bank=%0d, want 000/0",
                     bus.RD_DATA, bus.WR_BANK);
        end
    endtask

    task automatic test_basic();
        bus.LOAD = 1; bus.XPOS = 9'd10; bus.PAL = 8'h3C;
        tick(); idle();
        pair(4'd5, 4'd7, 1, 1);
        tick(); idle();
        checks++;
        if (bus.PIX_CNT !== 9'd2) begin
            errors++;
            $display("FAIL basic_cnt: got %0d want 2", bus.PIX_CNT);
        end
        bus.LINE_SWAP = 1;
        tick(); idle();
        checks++;
        if (bus.WR_BANK !== 1'b1 || bus.PIX_CNT !== 9'd0) begin
            errors++;
            $display("FAIL basic_swap: got bank=%0d cnt=%0d want 1/0",
                     bus.WR_BANK, bus.PIX_CNT);
        end
        read_at(10);
        checks++;
        if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== 12'h3C5) begin
            errors++;
            $display("FAIL basic_rd10: got v=%0d d=%h want 1/3c5",
                     bus.RD_VALID, bus.RD_DATA);
        end
        read_at(11);
        checks++;
        if (bus.RD_DATA !== 12'h3C7) begin
            errors++;
            $display("FAIL basic_rd11: got %h want 3c7", bus.RD_DATA);
        end
        tick();
        checks++;
        if (bus.RD_VALID !== 1'b0 || bus.RD_DATA !== 12'h3C7) begin
            errors++;
            $display("FAIL rd_hold: got v=%0d d=%h want 0/3c7",
                     bus.RD_VALID, bus.RD_DATA);
        end
        read_at(10);
        checks++;
        if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== 12'h000) begin
            errors++;
            $display("FAIL rd_clear: got v=%0d d=%h want 1/000",
                     bus.RD_VALID, bus.RD_DATA);
        end
    endtask

    task automatic test_transparent();
        bus.LOAD = 1; bus.XPOS = 9'd20; bus.PAL = 8'h01;
        pair(4'd1, 4'd0, 1, 0);
        tick(); idle();
        checks++;
        if (bus.PIX_CNT !== 9'd1) begin
            errors++;
            $display("FAIL transp_cnt1: got %0d want 1", bus.PIX_CNT);
        end
        bus.LOAD = 1; bus.XPOS = 9'd20; bus.PAL = 8'h55;
        pair(4'hF, 4'd9, 0, 1);
        tick(); idle();
        checks++;
        if (bus.PIX_CNT !== 9'd2) begin
            errors++;
            $display("FAIL transp_cnt2: got %0d want 2", bus.PIX_CNT);
        end
        bus.LINE_SWAP = 1;
        tick(); idle();
        read_at(20);
        checks++;
        if (bus.RD_DATA !== 12'h011) begin
            errors++;
            $display("FAIL transp_keep: got %h want 011", bus.RD_DATA);
        end
        read_at(21);
        checks++;
        if (bus.RD_DATA !== 12'h559) begin
            errors++;
            $display("FAIL transp_new: got %h want 559", bus.RD_DATA);
        end
    endtask

    task automatic test_edge();
        bus.LOAD = 1; bus.XPOS = 9'd382; bus.PAL = 8'h22;
        pair(4'd1, 4'd2, 1, 1);
        tick(); idle();
        pair(4'd3, 4'd4, 1, 1);
        tick();
        pair(4'd5, 4'd6, 1, 1);
        tick(); idle();
        checks++;
        if (bus.PIX_CNT !== 9'd2) begin
            errors++;
            $display("FAIL edge_cnt: got %0d want 2", bus.PIX_CNT);
        end
        // 62 pairs from 388 up to 510/511, all off the visible line
        for (int i = 0; i < 62; i++) begin
            pair(4'd8, 4'd9, 1, 1);
            tick();
        end
        idle();
        checks++;
        if (bus.PIX_CNT !== 9'd2) begin
            errors++;
            $display("FAIL edge_drop: got %0d want 2", bus.PIX_CNT);
        end
        pair(4'hA, 4'hB, 1, 1);
        tick(); idle();
        checks++;
        if (bus.PIX_CNT !== 9'd4) begin
            errors++;
            $display("FAIL edge_wrap: got %0d want 4", bus.PIX_CNT);
        end
        bus.LOAD = 1; bus.XPOS = 9'd510; bus.PAL = 8'h77;
        pair(4'd1, 4'd1, 1, 1);
        tick(); idle();
        pair(4'hC, 4'hD, 1, 1);
        tick(); idle();
        checks++;
        if (bus.PIX_CNT !== 9'd6) begin
            errors++;
            $display("FAIL edge_load510: got %0d want 6", bus.PIX_CNT);
        end
        bus.LINE_SWAP = 1;
        tick(); idle();
        read_at(382);
        checks++;
        if (bus.RD_DATA !== 12'h221) begin
            errors++;
            $display("FAIL edge_rd382: got %h want 221", bus.RD_DATA);
        end
        read_at(383);
        checks++;
        if (bus.RD_DATA !== 12'h222) begin
            errors++;
            $display("FAIL edge_rd383: got %h want 222", bus.RD_DATA);
        end
        read_at(0);
        checks++;
        if (bus.RD_DATA !== 12'h77C) begin
            errors++;
            $display("FAIL edge_rd0: got %h want 77c", bus.RD_DATA);
        end
        read_at(1);
        checks++;
        if (bus.RD_DATA !== 12'h77D) begin
            errors++;
            $display("FAIL edge_rd1: got %h want 77d", bus.RD_DATA);
        end
        read_at(510);
        checks++;
        if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== 12'h000) begin
            errors++;
            $display("FAIL edge_rd510: got v=%0d d=%h want 1/000",
                     bus.RD_VALID, bus.RD_DATA);
        end
    endtask

    task automatic test_swap_coincident();
        bus.LOAD = 1; bus.XPOS = 9'd40; bus.PAL = 8'h5A;
        tick(); idle();
        pair(4'd3, 4'd4, 1, 1);
        bus.LINE_SWAP = 1;
        tick(); idle();
        checks++;
        if (bus.WR_BANK !== 1'b0 || bus.PIX_CNT !== 9'd0) begin
            errors++;
            $display("FAIL coinc_swap: got bank=%0d cnt=%0d want 0/0",
                     bus.WR_BANK, bus.PIX_CNT);
        end
        read_at(40);
        checks++;
        if (bus.RD_DATA !== 12'h5A3) begin
            errors++;
            $display("FAIL coinc_rd40: got %h want 5a3", bus.RD_DATA);
        end
        read_at(41);
        checks++;
        if (bus.RD_DATA !== 12'h5A4) begin
            errors++;
            $display("FAIL coinc_rd41: got %h want 5a4", bus.RD_DATA);
        end
    endtask

    task automatic test_saturate();
        bus.LOAD = 1; bus.XPOS = 9'd0; bus.PAL = 8'h10;
        for (int i = 0; i < 400; i++) begin
            pair(4'd2, 4'd3, 1, 1);
            tick();
            bus.LOAD = 0;
        end
        idle();
        checks++;
        if (bus.PIX_CNT !== 9'd511) begin
            errors++;
            $display("FAIL sat_cnt: got %0d want 511", bus.PIX_CNT);
        end
        bus.LINE_SWAP = 1;
        tick(); idle();
        checks++;
        if (bus.PIX_CNT !== 9'd0) begin
            errors++;
            $display("FAIL sat_swap: got %0d want 0", bus.PIX_CNT);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bus.LOAD      = ($urandom_range(0, 7) == 0);
            bus.XPOS      = 9'($urandom_range(0, 511));
            bus.PAL       = 8'($urandom);
            bus.PIX_EN    = $urandom_range(0, 1);
            bus.GAD       = 4'($urandom);
            bus.GBD       = 4'($urandom);
            bus.DOTA      = $urandom_range(0, 1);
            bus.DOTB      = $urandom_range(0, 1);
            bus.LINE_SWAP = ($urandom_range(0, 63) == 0);
            bus.RD_EN     = $urandom_range(0, 1);
            bus.RD_X      = 9'($urandom_range(0, 511));
            tick();
            checks++;
            if (bus.WR_BANK !== 1'(m_bank) || bus.PIX_CNT !== 9'(m_cnt)) begin
                errors++;
                $display("FAIL rand_ctl @%0d: got bank=%0d cnt=%0d want %0d/%0d",
                         i, bus.WR_BANK, bus.PIX_CNT, m_bank, m_cnt);
            end
            checks++;
            if (bus.RD_VALID !== m_rv || bus.RD_DATA !== m_rd) begin
                errors++;
                $display("FAIL rand_rd @%0d: got v=%0d d=%h want %0d/%h",
                         i, bus.RD_VALID, bus.RD_DATA, m_rv, m_rd);
            end
        end
        idle();
    endtask

    task automatic test_reset_midline();
        if (m_bank == 0) begin
            bus.LINE_SWAP = 1;
            tick(); idle();
        end
        bus.LOAD = 1; bus.XPOS = 9'd100; bus.PAL = 8'h42;
        pair(4'd1, 4'd2, 1, 1);
        tick(); idle();
        bus.RD_EN = 1; bus.RD_X = 9'd5;
        tick();
        checks++;
        if (bus.WR_BANK !== 1'b1 || bus.PIX_CNT === 9'd0 || bus.RD_VALID !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got bank=%0d cnt=%0d v=%0d want 1/>0/1",
                     bus.WR_BANK, bus.PIX_CNT, bus.RD_VALID);
        end
        #2;
        nreset = 0;
        reset_model();
        #1;
        checks++;
        if (bus.WR_BANK !== 1'b0 || bus.PIX_CNT !== 9'd0 || bus.RD_VALID !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: got bank=%0d cnt=%0d v=%0d want 0/0/0",
                     bus.WR_BANK, bus.PIX_CNT, bus.RD_VALID);
        end
        tick();
        checks++;
        if (bus.RD_VALID !== 1'b0) begin
            errors++;
            $display("FAIL mid_hold: got v=%0d want 0", bus.RD_VALID);
        end
        nreset = 1;
        #1;
        checks++;
        if (bus.RD_VALID !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: got v=%0d want 0", bus.RD_VALID);
        end
        tick();
        checks++;
        if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== m_rd) begin
            errors++;
            $display("FAIL mid_resume: got v=%0d d=%h want 1/%h",
                     bus.RD_VALID, bus.RD_DATA, m_rd);
        end
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        clear_banks();
        test_basic();
        test_transparent();
        test_edge();
        test_swap_coincident();
        test_saturate();
        test_random();
        test_reset_midline();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/neo_linebuf_wr.md
NEO_LINEBUF_WR -- requirements
Module: neo_linebuf_wr

Interface
REQ-001 SHALL have parameter LB_WIDTH, default 384, giving the visible line-buffer entries per bank.
REQ-002 SHALL have port CLK_12M  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port nRESET  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port LOAD  in  1  start of a sprite tile row; loads the write X counter.
REQ-005 SHALL have port XPOS  in  9  X start position, sampled when LOAD=1.
REQ-006 SHALL have port PAL  in  8  palette index of the current sprite, sampled when LOAD=1.
REQ-007 SHALL have port PIX_EN  in  1  a GAD/GBD pixel pair is valid this cycle.
REQ-008 SHALL have port GAD  in  4  color index of even pixel (A).
REQ-009 SHALL have port GBD  in  4  color index of odd pixel (B).
REQ-010 SHALL have port DOTA  in  1  pixel A opaque.
REQ-011 SHALL have port DOTB  in  1  pixel B opaque.
REQ-012 SHALL have port LINE_SWAP  in  1  one-cycle pulse at line end; exchanges write and read banks.
REQ-013 SHALL have port RD_EN  in  1  display-side read request.
REQ-014 SHALL have port RD_X  in  9  display-side read address.
REQ-015 SHALL have port RD_DATA  out  12  {palette[7:0], color[3:0]} read result; 0 = transparent.
REQ-016 SHALL have port RD_VALID  out  1  RD_DATA valid this cycle.
REQ-017 SHALL have port WR_BANK  out  1  current write bank (0/1).
REQ-018 SHALL have port PIX_CNT  out  9  opaque pixels written to the write bank this line, saturating at 511.

Function
REQ-019 SHALL hold two banks of LB_WIDTH x 12-bit entries; the write side uses bank WR_BANK and the read side uses bank ~WR_BANK.
REQ-020 SHALL, on LOAD=1, set X counter := XPOS and PAL register := PAL.
REQ-021 SHALL, on PIX_EN=1, write {PAL_reg, GAD} to X if DOTA=1 and {PAL_reg, GBD} to X+1 if DOTB=1, then advance X by 2 modulo 512.
REQ-022 SHALL, on LOAD and PIX_EN in the same cycle, use the new XPOS and PAL for that cycle's pair, with X advancing to XPOS+2.
REQ-023 SHALL discard any pixel whose address is >= LB_WIDTH, with no write and no PIX_CNT increment; the counter still advances and wraps 511->0, so 510/511 discard and 0/1 write next.
REQ-024 SHALL let a later opaque write overwrite an earlier one at the same address (last sprite wins).
REQ-025 SHALL never write a transparent pixel, leaving the existing entry intact.
REQ-026 SHALL increment PIX_CNT by 0, 1 or 2 per cycle by the count of accepted pixels, saturating at 511.
REQ-027 SHALL perform read-with-clear: on RD_EN=1, return the entry at RD_X of the read bank on RD_DATA one cycle later with RD_VALID=1, and zero that entry in the same cycle.
REQ-028 SHALL return RD_DATA=0 with RD_VALID=1 for RD_X >= LB_WIDTH.
REQ-029 SHALL hold RD_DATA at its last value while RD_EN=0, with RD_VALID=0.
REQ-030 SHALL, on LINE_SWAP=1, toggle WR_BANK and clear PIX_CNT to 0 at that edge.
REQ-031 SHALL direct any PIX_EN writes in the LINE_SWAP cycle to the old (pre-toggle) bank, excluding them from the new PIX_CNT.
REQ-032 SHALL direct any RD_EN reads in the LINE_SWAP cycle to the old read bank.
REQ-033 SHALL NOT let the X counter or PAL register be affected by LINE_SWAP.
REQ-034 SHALL never address the same bank from both read and write sides in one cycle.

Reset
REQ-035 SHALL, while nRESET=0, asynchronously force WR_BANK=0, X=0, PAL_reg=0, PIX_CNT=0, RD_DATA=0, RD_VALID=0.
REQ-036 SHALL NOT clear bank contents on reset; the bench clears them via one full read pass per bank.
REQ-037 SHALL, if nRESET is asserted mid-line, drop any in-flight read so that RD_VALID=0 on the first cycle after release.

Verification
REQ-038 SHALL cover: LOAD XPOS=10 PAL=0x3C, PIX_EN GAD=5 GBD=7 DOTA=DOTB=1, LINE_SWAP, RD_X=10 then 11 -> RD_DATA 0x3C5 then 0x3C7, PIX_CNT=2 before swap.
REQ-039 SHALL cover: DOTA=0 DOTB=1 at X=20 over prior entry 0x011 -> X=20 keeps 0x011, X=21 takes the new value, PIX_CNT +1.
REQ-040 SHALL cover: LOAD XPOS=382, three pairs -> writes 382 and 383 only, X=388, PIX_CNT=2; then XPOS=510 -> 510/511 dropped, 0/1 written.
REQ-041 SHALL cover: reading X=10 twice after the swap -> 0x3C5, then 0x000 (cleared).
REQ-042 SHALL cover: LINE_SWAP coincident with PIX_EN at X=40 -> pixel lands in the old bank, readable after the swap, PIX_CNT=0.
REQ-043 SHALL cover: nRESET pulse mid-line with RD_EN held -> WR_BANK=0, PIX_CNT=0, RD_VALID=0 immediately, reads resume one cycle after release.
